// File: rtl/evt_readout_scheduler.sv
// Merges one event per channel FIFO into a single header/payload/trailer stream.
// Optional stall-timeout abort is built when EVT_TIMEOUT_EN is defined.
module evt_readout_scheduler #(
  parameter int NCH     = 2,
  parameter int TMO_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             need_check,
  input  logic [NCH-1:0]   ch_empty,
  input  logic [16*NCH-1:0] ch_dout,
  output logic [NCH-1:0]   ch_rd_en,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [15:0]      tx_data,
  output logic [15:0]      evt_tx,
  output logic             busy,
  output logic             err_timeout
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    TRL
  } state_t;

  state_t        state, state_n;
  logic [3:0]    pend;
  logic [CW-1:0] sel, sel_n;
  logic [11:0]   cnt, cnt_n;
  logic [15:0]   head;
  logic          head_empty;
  logic          last_ch;
  logic          xfer;
  logic          done;
  logic          abort;
  logic          tmo_hit;

  assign head       = ch_dout[16*int'(sel) +: 16];
  assign head_empty = ch_empty[sel];
  assign last_ch    = (int'(sel) == NCH - 1);
  assign busy       = (state != IDLE) && !reset;

`ifdef EVT_TIMEOUT_EN
  logic [15:0] stall;
  logic        stalled;

  assign stalled = ((state == HDR) || (state == PAY)) && head_empty;
  assign tmo_hit = stalled && !reset && (stall == 16'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall       <= '0;
      abort       <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (stalled && !tmo_hit) stall <= stall + 16'd1;
      else                     stall <= '0;
      if (tmo_hit) begin
        abort       <= 1'b1;
        err_timeout <= 1'b1;
      end else if (done) begin
        abort <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    sel_n    = sel;
    cnt_n    = cnt;
    tx_valid = 1'b0;
    tx_data  = head;
    xfer     = 1'b0;
    done     = 1'b0;
    ch_rd_en = '0;
    unique case (state)
      IDLE: begin
        if ((pend != 4'd0) || need_check) begin
          state_n = HDR;
          sel_n   = '0;
        end
      end
      HDR: begin
        tx_valid = !head_empty;
        xfer     = tx_valid && tx_ready;
        if (xfer) begin
          if (head[11:0] == 12'd0) begin
            if (last_ch) state_n = TRL;
            else         sel_n   = sel + 1'b1;
          end else begin
            cnt_n   = head[11:0];
            state_n = PAY;
          end
        end
      end
      PAY: begin
        tx_valid = !head_empty;
        xfer     = tx_valid && tx_ready;
        if (xfer) begin
          if (cnt == 12'd1) begin
            if (last_ch) begin
              state_n = TRL;
            end else begin
              sel_n   = sel + 1'b1;
              state_n = HDR;
            end
          end else begin
            cnt_n = cnt - 12'd1;
          end
        end
      end
      TRL: begin
        tx_valid = 1'b1;
        tx_data  = {abort ? 4'hF : 4'hE, evt_tx[11:0]};
        done     = tx_ready;
        if (tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (tmo_hit) state_n = TRL;
    // outputs stay quiet while reset is asserted, whatever the state
    if (reset) begin
      tx_valid = 1'b0;
      xfer     = 1'b0;
      done     = 1'b0;
    end
    ch_rd_en[sel] = xfer;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= '0;
      cnt    <= '0;
      evt_tx <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      if (done) evt_tx <= evt_tx + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (need_check && !done) begin
      if (pend != 4'd15) pend <= pend + 4'd1;
    end else if (done && !need_check) begin
      pend <= pend - 4'd1;
    end
  end

endmodule

// File: doc/evt_readout_scheduler.md
EVT_READOUT_SCHEDULER -- requirements
Module: evt_readout_scheduler

Interface
REQ-001 SHALL have parameter: NCH, 2, number of channel FIFOs sequenced (1..16).
REQ-002 SHALL have parameter: TMO_CYC, 65535, stall cycles before timeout abort (used only with EVT_TIMEOUT_EN).
REQ-003 SHALL have port: clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port: need_check  in  1  one-cycle pulse; one complete event is available in every channel.
REQ-006 SHALL have port: ch_empty  in  NCH  per-channel FIFO empty flag (first-word-fall-through FIFOs).
REQ-007 SHALL have port: ch_dout  in  16*NCH  per-channel FIFO head word; channel k occupies bits [16k+15:16k].
REQ-008 SHALL have port: ch_rd_en  out  NCH  per-channel pop strobe.
REQ-009 SHALL have port: tx_ready  in  1  downstream accepts tx_data this cycle.
REQ-010 SHALL have port: tx_valid  out  1  tx_data valid.
REQ-011 SHALL have port: tx_data  out  16  merged event stream word.
REQ-012 SHALL have port: evt_tx  out  16  count of events fully read out (fed back to the receive manager).
REQ-013 SHALL have port: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port: err_timeout  out  1  sticky timeout flag.

Function
REQ-015 SHALL keep a 4-bit pending counter: +1 on need_check, -1 on event completion, unchanged when both happen in the same cycle, saturating at 15 (further pulses dropped).
REQ-016 SHALL implement states IDLE, HDR, PAY, TRL.
- IDLE->HDR when pending>0.
- HDR->PAY, or HDR->HDR of the next channel, after the header transfer.
- PAY->HDR of the next channel, or PAY->TRL, after the last payload word.
- TRL->IDLE after the trailer transfer.
REQ-017 SHALL start each event at channel 0 and visit channels 0..NCH-1 in ascending order, with one event per channel.
REQ-018 SHALL read the payload length L from header bits [11:0] (0..4095).
- L=0 skips PAY.
- Header bits [15:12] are passed through unmodified.
REQ-019 SHALL drive tx_valid=1 in HDR/PAY only while ch_empty[sel]=0, with tx_data=ch_dout[sel].
REQ-020 SHALL make ch_rd_en[sel]=tx_valid&&tx_ready combinationally, and keep all other ch_rd_en bits 0.
REQ-021 SHALL make a transfer occur only in a cycle where tx_valid&&tx_ready; with tx_ready=0, tx_data and state hold.
REQ-022 SHALL present in TRL tx_valid=1 and tx_data={4'hE, evt_tx[11:0]} using the pre-increment count, with no FIFO pop.
REQ-023 SHALL increment evt_tx by 1 on the cycle the trailer transfers, wrapping 16'hFFFF->0; this is the completion event for REQ-015.
REQ-024 SHALL have a latency of 1 cycle from need_check (pending 0->1) to first possible tx_valid; back-to-back events SHALL have no idle cycle between TRL and the next HDR beyond the single IDLE cycle.
REQ-025 SHALL hold the 12-bit payload countdown reloaded at each header; tx_data SHALL be unregistered (combinational from ch_dout), with no added pipeline latency.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, pending=0, evt_tx=0, err_timeout=0, and the payload counter and channel index to 0.
REQ-027 SHALL drive tx_valid=0, ch_rd_en=0, busy=0 while reset is high and in the cycle after.
REQ-028 SHALL, on reset mid-event, abandon the event with no trailer and no evt_tx increment; FIFO contents are not flushed.
REQ-029 SHALL give reset priority over a coincident need_check, which is lost.

Configuration
REQ-030 SHALL support macro EVT_TIMEOUT_EN.
- Defined: a 16-bit stall counter counts cycles in HDR/PAY with ch_empty[sel]=1 and clears on any transfer.
- On reaching TMO_CYC: jump to TRL, set err_timeout=1 (sticky until reset), and use trailer {4'hF, evt_tx[11:0]}.
- evt_tx still increments.
REQ-031 SHALL, without EVT_TIMEOUT_EN, wait indefinitely on an empty FIFO, tie err_timeout to 0, and contain no stall counter.

Verification
REQ-032 SHALL cover: NCH=2, ch0 {0x0002,A,B}, ch1 {0x0001,C}, one need_check, tx_ready=1 -> stream 0x0002,A,B,0x0001,C,0xE000; evt_tx 0->1; busy falls after trailer.
REQ-033 SHALL cover: the same event with tx_ready toggling 1/0 each cycle -> identical word sequence, no duplicate pops, ch_rd_en never high when tx_ready=0.
REQ-034 SHALL cover: both headers 0x5000 (L=0) -> stream 0x5000,0x5000,0xE000; evt_tx=1.
REQ-035 SHALL cover: 17 need_check pulses before any data -> pending saturates at 15; exactly 15 events drained; evt_tx=15.
REQ-036 SHALL cover: with EVT_TIMEOUT_EN and TMO_CYC=8, ch1 empty after ch0 done -> trailer 0xF000 after 8 stall cycles; err_timeout=1; evt_tx=1. Without the macro -> stalls; err_timeout stays 0.
REQ-037 SHALL cover: reset asserted during ch0 payload -> next cycle IDLE, evt_tx=0, no trailer emitted.
